// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared constants for the UART byte/word converters (8-to-32 receive side
// and 32-to-8 transmit side).
//   BYTE_W       : width of one UART byte (8)
//   WORD_W       : width of an assembled word (32)
//   conv_state_t : 2-bit byte-position state type
//   S_B0..S_B3   : byte-position states; the value equals the number of
//                  bytes already held in the current partial word
// ---------------------------------------------------------------------------
package conv_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  typedef logic [1:0] conv_state_t;

  localparam logic [1:0] S_B0 = 2'd0;
  localparam logic [1:0] S_B1 = 2'd1;
  localparam logic [1:0] S_B2 = 2'd2;
  localparam logic [1:0] S_B3 = 2'd3;

endpackage

// File: rtl/rx_gap_timer.sv
// ---------------------------------------------------------------------------
// rx_gap_timer
// Inter-byte gap timer for data8to32. Only compiled when the macro
// DATA8TO32_TIMEOUT_EN is defined.
//   Parameter TIMEOUT_CYCLES : gap length (sys_clk cycles) that expires
//   sys_clk : clock, rising edge
//   reset   : synchronous active-high reset
//   clr     : restart the count (a byte arrived)
//   run     : count only while a partial word is held
//   expired : high in the cycle the count reaches TIMEOUT_CYCLES-1
// ---------------------------------------------------------------------------
`ifdef DATA8TO32_TIMEOUT_EN
module rx_gap_timer #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic expired
);

  logic [15:0] count;

  assign expired = run && (count == (TIMEOUT_CYCLES - 16'd1));

  // The count restarts on every byte and whenever no partial word is held,
  // so an expiry always measures the gap since the most recent byte.
  always_ff @(posedge sys_clk) begin
    if (reset || clr || !run || expired) begin
      count <= '0;
    end else begin
      count <= count + 16'd1;
    end
  end

endmodule
`endif

// File: rtl/data8to32.sv
// ---------------------------------------------------------------------------
// data8to32
// Packs four UART bytes (MSB first) into a 32-bit word with a valid/ack
// handshake and a sticky overrun flag.
//   Parameter TIMEOUT_CYCLES : inter-byte gap after which a partial word is
//                              dropped (used only with DATA8TO32_TIMEOUT_EN)
//   Macro DATA8TO32_TIMEOUT_EN : enables the gap timeout (rx_gap_timer);
//                                without it a partial word waits forever
//   sys_clk    : clock, rising edge
//   reset      : synchronous active-high reset
//   in_8       : received byte, stable while rx_done is high
//   rx_done    : byte-complete level, only its rising edge counts
//   rd_ack     : consumer acknowledge, clears word_valid
//   out_32     : last completed word
//   word_valid : out_32 holds an unconsumed word
//   overrun    : sticky, a word completed while the previous one was unread
//   byte_cnt   : bytes held in the current partial word
// ---------------------------------------------------------------------------
module data8to32
  import conv_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] in_8,
  input  logic              rx_done,
  input  logic              rd_ack,
  output logic [WORD_W-1:0] out_32,
  output logic              word_valid,
  output logic              overrun,
  output logic [1:0]        byte_cnt
);

  conv_state_t              state;
  logic                     rx_done_q;
  logic                     strobe;
  logic                     complete;
  logic                     gap_expired;
  logic [WORD_W-1:BYTE_W]   held;

  // rx_done may stay high for many cycles; only its rising edge is a byte.
  assign strobe   = rx_done && !rx_done_q;
  assign complete = strobe && (state == S_B3);
  assign byte_cnt = state;

`ifdef DATA8TO32_TIMEOUT_EN
  rx_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .sys_clk (sys_clk),
    .reset   (reset),
    .clr     (strobe),
    .run     (state != S_B0),
    .expired (gap_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign gap_expired    = 1'b0;
`endif

  // Byte-position FSM and partial-word shift register. A strobe beats a
  // simultaneous gap expiry because the new byte restarts the gap.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state     <= S_B0;
      held      <= '0;
      rx_done_q <= 1'b0;
    end else begin
      rx_done_q <= rx_done;
      if (strobe) begin
        case (state)
          S_B0: begin
            held[WORD_W-1 -: BYTE_W]          <= in_8;
            state                             <= S_B1;
          end
          S_B1: begin
            held[WORD_W-BYTE_W-1 -: BYTE_W]   <= in_8;
            state                             <= S_B2;
          end
          S_B2: begin
            held[WORD_W-2*BYTE_W-1 -: BYTE_W] <= in_8;
            state                             <= S_B3;
          end
          default: begin
            state                             <= S_B0;
          end
        endcase
      end else if (gap_expired) begin
        state <= S_B0;
        held  <= '0;
      end
    end
  end

  // Output word and handshake. Completion takes priority over rd_ack, and
  // an ack in the completion cycle consumes the old word, so no overrun.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      out_32     <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (complete) begin
      out_32     <= {held, in_8};
      word_valid <= 1'b1;
      if (word_valid && !rd_ack) begin
        overrun <= 1'b1;
      end
    end else if (rd_ack) begin
      word_valid <= 1'b0;
    end
  end

endmodule
